// File: rtl/imem_boot_loader.sv
// Boot loader: assembles little-endian 32-bit words from a byte stream and writes them to
// consecutive instruction-memory words, holding the processor in reset until the load is done.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   Load_Count,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              IMEM_WrEn,
    output logic [ADDR_W-1:0] IMEM_Addr,
    output logic [31:0]       IMEM_DataIn,
    output logic              Proc_Reset,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   target_q, target_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wren_q, wren_d;
    logic              proc_reset_q, proc_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   clamp_s;
    logic              accept_s;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        target_d   = target_q;
        addr_d     = addr_q;
        data_d     = data_q;
        // Clamping to the memory depth is what keeps IMEM_Addr from wrapping.
        clamp_s    = (Load_Count > MAX_WORDS) ? MAX_WORDS : Load_Count;
        accept_s   = (state_q == RECV) && Byte_Valid && byte_ready_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    target_d   = clamp_s;
                    word_cnt_d = {(ADDR_W+1){1'b0}};
                    byte_cnt_d = 2'd0;
                    addr_d     = {ADDR_W{1'b0}};
                    state_d    = (clamp_s == {(ADDR_W+1){1'b0}}) ? DONE : RECV;
                end else begin
                    state_d = state_q;
                end
            end
            RECV: begin
                if (accept_s) begin
                    data_d[{byte_cnt_q, 3'b000} +: 8] = Byte_In;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = (byte_cnt_q == 2'd3) ? WRITE : RECV;
                end else begin
                    state_d = RECV;
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + ONE_CNT;
                if (word_cnt_d == target_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ONE_ADDR;
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the next state's decode, so they line up with state_q.
        byte_ready_d = (state_d == RECV);
        wren_d       = (state_d == WRITE);
        proc_reset_d = (state_d != DONE);
        busy_d       = (state_d == RECV) || (state_d == WRITE);
        done_d       = (state_d == DONE);
    end

    // State, counters and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= {(ADDR_W+1){1'b0}};
            target_q     <= {(ADDR_W+1){1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= 32'h0000_0000;
            byte_ready_q <= 1'b0;
            wren_q       <= 1'b0;
            proc_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            target_q     <= target_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= byte_ready_d;
            wren_q       <= wren_d;
            proc_reset_q <= proc_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign Byte_Ready  = byte_ready_q;
    assign IMEM_WrEn   = wren_q;
    assign IMEM_Addr   = addr_q;
    assign IMEM_DataIn = data_q;
    assign Proc_Reset  = proc_reset_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: drives/samples on the falling edge and checks
// captured memory writes against hand-computed words.
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [ADDR_W:0]   Load_Count;
    logic [7:0]        Byte_In;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic              IMEM_WrEn;
    logic [ADDR_W-1:0] IMEM_Addr;
    logic [31:0]       IMEM_DataIn;
    logic              Proc_Reset;
    logic              Busy;
    logic              Done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]       mem [0:1023];
    int                wr_count  = 0;
    int                br_cycles = 0;
    int                cyc       = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Load_Count(Load_Count),
        .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
        .IMEM_WrEn(IMEM_WrEn), .IMEM_Addr(IMEM_Addr), .IMEM_DataIn(IMEM_DataIn),
        .Proc_Reset(Proc_Reset), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Memory model and activity counters
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Byte_Ready) br_cycles <= br_cycles + 1;
        if (IMEM_WrEn) begin
            mem[IMEM_Addr] <= IMEM_DataIn;
            wr_count       <= wr_count + 1;
            last_addr      <= IMEM_Addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        Byte_In    = b;
        Byte_Valid = 1'b1;
        while (!Byte_Ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) chk("byte_ready_timeout", 64'd0, 64'd1);
        @(negedge Clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            if (gap > 0) begin
                Byte_Valid = 1'b0;
                repeat (gap) @(negedge Clk);
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic do_start(input logic [ADDR_W:0] cnt);
        Load_Count = cnt;
        Start      = 1'b1;
        @(negedge Clk);
        Start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        Byte_Valid = 1'b0;
        while (!Done && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk(tag, Done, 1);
    endtask

    initial begin
        int base_wr, base_br, t0, t1;
        Reset = 1'b1; Start = 1'b0; Load_Count = '0; Byte_In = 8'h00; Byte_Valid = 1'b0;

        // Reset state
        @(negedge Clk);
        chk("rst_state", {Byte_Ready, IMEM_WrEn, Proc_Reset, Busy, Done}, 5'b00100);
        chk("rst_addr", IMEM_Addr, 0);
        chk("rst_data", IMEM_DataIn, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Two-word load, back-to-back bytes
        base_wr = wr_count;
        do_start(11'd2);
        chk("start_busy_ready", {Busy, Byte_Ready, Proc_Reset, Done}, 4'b1110);
        t0 = cyc;
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_done("two_word_done");
        t1 = cyc;
        chk("two_word_latency", t1 - t0, 10);
        chk("two_word_writes", wr_count - base_wr, 2);
        chk("two_word_addr0", mem[0], 32'h1234_5678);
        chk("two_word_addr1", mem[1], 32'hDEAD_BEEF);
        chk("two_word_final", {Proc_Reset, Busy, Byte_Ready, IMEM_WrEn}, 4'b0000);

        // Zero count: straight to DONE, no bytes, no writes
        Reset = 1'b1; @(negedge Clk); Reset = 1'b0; @(negedge Clk);
        base_wr = wr_count; base_br = br_cycles;
        do_start(11'd0);
        chk("zero_done_next", {Done, Proc_Reset, Busy}, 3'b100);
        repeat (3) @(negedge Clk);
        chk("zero_no_write", wr_count - base_wr, 0);
        chk("zero_no_ready", br_cycles - base_br, 0);

        // Backpressure with gaps, valid held across WRITE, Start ignored in RECV
        base_wr = wr_count;
        do_start(11'd3);
        send_byte(8'h01);
        send_byte(8'h02);
        Byte_Valid = 1'b0;
        Load_Count = 11'd0;
        Start      = 1'b1;
        @(negedge Clk);
        Start      = 1'b0;
        chk("start_ignored_recv", {Busy, Byte_Ready, Done}, 3'b110);
        send_byte(8'h03);
        Byte_Valid = 1'b0;
        repeat (2) @(negedge Clk);
        send_byte(8'h04);
        send_word(32'hCAFE_F00D, 2);
        send_word(32'h0BAD_C0DE, 1);
        wait_done("bp_done");
        chk("bp_writes", wr_count - base_wr, 3);
        chk("bp_addr0", mem[0], 32'h0403_0201);
        chk("bp_addr1", mem[1], 32'hCAFE_F00D);
        chk("bp_addr2", mem[2], 32'h0BAD_C0DE);

        // Clamp: 1025 requested, 1024 written
        base_wr = wr_count;
        do_start(11'd1025);
        for (int i = 0; i < 1024; i++) send_word(32'h1000_0000 + i, 0);
        wait_done("clamp_done");
        chk("clamp_writes", wr_count - base_wr, 1024);
        chk("clamp_last_addr", last_addr, 1023);
        chk("clamp_mem1023", mem[1023], 32'h1000_03FF);
        chk("clamp_mem512", mem[512], 32'h1000_0200);
        repeat (3) @(negedge Clk);
        chk("clamp_no_extra", wr_count - base_wr, 1024);

        // Reset mid-load after 6 bytes of a 3-word load
        do_start(11'd3);
        send_word(32'h7777_6666, 0);
        send_byte(8'h55);
        send_byte(8'h44);
        Reset = 1'b1;
        #1;
        chk("midrst_outputs", {Byte_Ready, IMEM_WrEn, Proc_Reset, Busy, Done}, 5'b00100);
        chk("midrst_data", IMEM_DataIn, 0);
        chk("midrst_addr", IMEM_Addr, 0);
        @(negedge Clk);
        Reset = 1'b0;
        Byte_Valid = 1'b0;
        @(negedge Clk);
        chk("midrst_idle", {Proc_Reset, Busy, Done}, 3'b100);

        // Reload one word, then restart from DONE
        base_wr = wr_count;
        do_start(11'd1);
        send_word(32'hA5A5_A5A5, 0);
        wait_done("reload_done");
        chk("reload_addr0", mem[0], 32'hA5A5_A5A5);
        chk("reload_writes", wr_count - base_wr, 1);
        base_wr = wr_count;
        do_start(11'd2);
        chk("restart_proc_reset", {Proc_Reset, Done, Busy}, 3'b101);
        send_word(32'h1122_3344, 0);
        send_word(32'h5566_7788, 1);
        wait_done("restart_done");
        chk("restart_addr0", mem[0], 32'h1122_3344);
        chk("restart_addr1", mem[1], 32'h5566_7788);
        chk("restart_writes", wr_count - base_wr, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader that sits directly upstream of the processor's instruction fetch stage. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into consecutive instruction-memory locations. While loading, it holds the processor in reset; it releases that reset once the programmed word count has been written.

## Interface
- ADDR_W, 10, instruction-memory word-address width (depth 2^ADDR_W words)
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  single-cycle request to begin a load; sampled only in IDLE and DONE
- Load_Count  input  ADDR_W+1  number of words to load; sampled on accepted Start
- Byte_In  input  8  stream data byte
- Byte_Valid  input  1  Byte_In is valid
- Byte_Ready  output  1  loader can accept a byte this cycle
- IMEM_WrEn  output  1  instruction-memory write enable, one cycle per word
- IMEM_Addr  output  ADDR_W  instruction-memory word address
- IMEM_DataIn  output  32  instruction word to write
- Proc_Reset  output  1  reset to processor (PC, control); high while not DONE
- Busy  output  1  load in progress (RECV or WRITE)
- Done  output  1  load complete, processor running

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs are decoded from registered state or registers (no combinational input-to-output paths).
- Reset values: state IDLE, Byte_Ready 0, IMEM_WrEn 0, IMEM_Addr 0, IMEM_DataIn 0, Proc_Reset 1, Busy 0, Done 0, byte counter 0, word counter 0.
- IDLE and Start:
  - Latch the target count = min(Load_Count, 2^ADDR_W).
  - Clear the word counter, byte counter and IMEM_Addr.
  - If the target is 0, go to DONE; otherwise go to RECV.
- RECV:
  - Byte_Ready = 1.
  - Each byte is accepted on a rising edge with Byte_Valid && Byte_Ready.
  - The k-th accepted byte (k = 0..3) goes to IMEM_DataIn[8k+7:8k]; the byte counter increments mod 4.
  - On acceptance of byte 3, go to WRITE.
  - Byte_Valid low stalls RECV indefinitely with no state change.
- WRITE:
  - Byte_Ready = 0 and IMEM_WrEn = 1 for exactly one cycle; IMEM_Addr and IMEM_DataIn are stable.
  - At the end of the cycle, increment the word counter.
  - If the incremented counter equals the target, go to DONE. Otherwise increment IMEM_Addr and return to RECV.
- DONE:
  - Proc_Reset = 0 and Done = 1; Byte_Ready = 0; IMEM_WrEn = 0.
  - Start in DONE behaves as in IDLE: reasserts Proc_Reset from the next cycle and reloads from address 0.
- Start is ignored in RECV and WRITE. Bytes presented outside RECV are not accepted.
- IMEM_Addr never exceeds 2^ADDR_W−1; the clamp guarantees no wrap-around.

## Timing
- Start accepted at edge N: Busy = 1 and Byte_Ready = 1 from cycle N+1 (count > 0), or Done = 1 and Proc_Reset = 0 from N+1 (count = 0).
- Write timing: 4th byte accepted at edge M → IMEM_WrEn high during cycle M+1 → write committed at edge M+2 → Byte_Ready high again from M+2.
- Minimum 5 cycles per word with Byte_Valid held high.
- Last word: DONE entered at the edge that commits the final write; Proc_Reset falls in that same cycle.
- Reset asserted mid-load: immediate return to reset values. Partial word is discarded; words already written remain in memory but are not re-validated. Proc_Reset is high throughout.
- Reset release: first possible Start is sampled at the first rising edge after Reset deasserts.

## Test plan
- Reset: assert Reset mid-cycle → all outputs at reset values immediately, Proc_Reset = 1, state IDLE.
- Two-word load: Start, Load_Count = 2; bytes 78,56,34,12,EF,BE,AD,DE back-to-back → IMEM writes addr0 = 0x12345678 and addr1 = 0xDEADBEEF, each with a one-cycle IMEM_WrEn; Done = 1 and Proc_Reset = 0 from the cycle after the second write; 10 cycles from first Byte_Ready to Done.
- Zero count: Start, Load_Count = 0 → Done = 1 the next cycle, no IMEM_WrEn, Byte_Ready never high.
- Backpressure: random Byte_Valid gaps plus Byte_Valid held during WRITE → no byte lost or duplicated; data matches scoreboard; Start pulses during RECV are ignored.
- Clamp: ADDR_W = 10, Load_Count = 1025 → exactly 1024 writes, last IMEM_Addr = 1023, then DONE.
- Reset mid-load and reload: Reset after 6 bytes of a 3-word load → IDLE, Proc_Reset = 1. Then Start with 1 word 0xA5A5A5A5 → addr0 = 0xA5A5A5A5, DONE. Start again from DONE → Proc_Reset reasserted the next cycle and reload proceeds correctly.
